// File: rtl/dec_scan_sequencer.sv
// Scan sequencer driving a 4-to-16 decoder: sweeps enabled lines in order.
// Ports: Clock/Resetn, Start/Stop/Mode/Dwell/Mask in; W/En/LineStrobe/Done out.
module dec_scan_sequencer #(
  parameter int DWELL_W = 8
) (
  input  logic               Clock,
  input  logic               Resetn,
  input  logic               Start,
  input  logic               Stop,
  input  logic               Mode,
  input  logic [DWELL_W-1:0] Dwell,
  input  logic [15:0]        Mask,
  output logic [3:0]         W,
  output logic               En,
  output logic               LineStrobe,
  output logic               Done
);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  state_t             state, state_n;
  logic [DWELL_W-1:0] cnt, cnt_n;
  logic [3:0]         w_n;
  logic               ls_n;
  logic               done_n;
  logic [3:0]         lo;
  logic [3:0]         nx;
  logic               nx_ok;
  logic               any;

  assign any = |Mask;

  // Downward loops so the last hit is the lowest index.
  always_comb begin
    lo    = 4'd0;
    nx    = 4'd0;
    nx_ok = 1'b0;
    for (int i = 15; i >= 0; i--) begin
      if (Mask[i]) begin
        lo = 4'(i);
      end
      if (Mask[i] && (i > int'(W))) begin
        nx    = 4'(i);
        nx_ok = 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    w_n     = W;
    ls_n    = 1'b0;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!Stop && Start && any) begin
          state_n = ACTIVE;
          w_n     = lo;
          cnt_n   = Dwell;
          ls_n    = 1'b1;
        end
      end
      ACTIVE: begin
        if (Stop) begin
          state_n = IDLE;
        end else if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else if (!any) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else if (nx_ok) begin
          w_n   = nx;
          cnt_n = Dwell;
          ls_n  = 1'b1;
        end else if (Mode) begin
          w_n   = lo;
          cnt_n = Dwell;
          ls_n  = 1'b1;
        end else begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state      <= IDLE;
      cnt        <= '0;
      W          <= 4'd0;
      En         <= 1'b0;
      LineStrobe <= 1'b0;
      Done       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      W          <= w_n;
      En         <= (state_n == ACTIVE);
      LineStrobe <= ls_n;
      Done       <= done_n;
    end
  end

endmodule

// File: tb/tb_dec_scan_sequencer.sv
// Bench for dec_scan_sequencer: per-cycle expected outputs queued, then popped.
// Drives all ports; samples 1 time unit after each rising edge.
module tb_dec_scan_sequencer;

  typedef struct packed {
    logic [3:0] w;
    logic       en;
    logic       ls;
    logic       done;
  } obs_t;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic        Start;
  logic        Stop;
  logic        Mode;
  logic [7:0]  Dwell;
  logic [15:0] Mask;
  logic [3:0]  W;
  logic        En;
  logic        LineStrobe;
  logic        Done;

  obs_t exp_q[$];
  obs_t got;
  obs_t want;
  int   checks   = 0;
  int   failures = 0;

  dec_scan_sequencer #(.DWELL_W(8)) dut (
    .Clock(Clock),
    .Resetn(Resetn),
    .Start(Start),
    .Stop(Stop),
    .Mode(Mode),
    .Dwell(Dwell),
    .Mask(Mask),
    .W(W),
    .En(En),
    .LineStrobe(LineStrobe),
    .Done(Done)
  );

  always #5 Clock = ~Clock;

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  function automatic obs_t mk(int w, bit en, bit ls, bit dn);
    obs_t o;
    o.w    = 4'(w);
    o.en   = en;
    o.ls   = ls;
    o.done = dn;
    return o;
  endfunction

  task automatic test_reset;
    Resetn = 1'b0;
    Start  = 1'b1;
    Stop   = 1'b0;
    Mode   = 1'b0;
    Dwell  = 8'd0;
    Mask   = 16'hffff;
    exp_q.push_back(mk(0, 0, 0, 0));
    exp_q.push_back(mk(0, 0, 0, 0));
    for (int c = 0; exp_q.size() != 0; c++) begin
      tick();
      got  = {W, En, LineStrobe, Done};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL reset c=%0d got=%p want=%p", c, got, want);
      end
    end
    Start  = 1'b0;
    Resetn = 1'b1;
    tick();
  endtask

  task automatic test_single_sweep;
    Mask  = 16'hffff;
    Dwell = 8'd0;
    Mode  = 1'b0;
    for (int i = 0; i < 16; i++) exp_q.push_back(mk(i, 1, 1, 0));
    exp_q.push_back(mk(15, 0, 0, 1));
    exp_q.push_back(mk(15, 0, 0, 0));
    for (int c = 0; exp_q.size() != 0; c++) begin
      Start = (c == 0);
      tick();
      got  = {W, En, LineStrobe, Done};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL sweep c=%0d got=%p want=%p", c, got, want);
      end
    end
    Start = 1'b0;
  endtask

  task automatic test_continuous;
    Mask  = 16'h8421;
    Dwell = 8'd2;
    Mode  = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int l = 0; l < 4; l++) begin
        exp_q.push_back(mk(l * 5, 1, 1, 0));
        exp_q.push_back(mk(l * 5, 1, 0, 0));
        exp_q.push_back(mk(l * 5, 1, 0, 0));
      end
    end
    exp_q.push_back(mk(15, 0, 0, 0));
    for (int c = 0; exp_q.size() != 0; c++) begin
      Start = (c == 0);
      Stop  = (c == 24);
      tick();
      got  = {W, En, LineStrobe, Done};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL continuous c=%0d got=%p want=%p", c, got, want);
      end
    end
    Start = 1'b0;
    Stop  = 1'b0;
  endtask

  task automatic test_stop;
    Mask  = 16'h8421;
    Dwell = 8'd2;
    Mode  = 1'b1;
    exp_q.push_back(mk(0, 1, 1, 0));
    exp_q.push_back(mk(0, 1, 0, 0));
    exp_q.push_back(mk(0, 1, 0, 0));
    exp_q.push_back(mk(5, 1, 1, 0));
    exp_q.push_back(mk(5, 1, 0, 0));
    exp_q.push_back(mk(5, 0, 0, 0));
    exp_q.push_back(mk(5, 0, 0, 0));
    exp_q.push_back(mk(0, 1, 1, 0));
    exp_q.push_back(mk(0, 1, 0, 0));
    exp_q.push_back(mk(0, 0, 0, 0));
    for (int c = 0; exp_q.size() != 0; c++) begin
      Start = (c == 0) || (c == 6) || (c == 7);
      Stop  = (c == 5) || (c == 6) || (c == 9);
      tick();
      got  = {W, En, LineStrobe, Done};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL stop c=%0d got=%p want=%p", c, got, want);
      end
    end
    Start = 1'b0;
    Stop  = 1'b0;
  endtask

  task automatic test_reset_mid;
    Mask  = 16'hffff;
    Dwell = 8'd0;
    Mode  = 1'b0;
    for (int i = 0; i < 8; i++) exp_q.push_back(mk(i, 1, 1, 0));
    exp_q.push_back(mk(0, 0, 0, 0));
    exp_q.push_back(mk(0, 0, 0, 0));
    exp_q.push_back(mk(0, 1, 1, 0));
    exp_q.push_back(mk(1, 1, 1, 0));
    exp_q.push_back(mk(1, 0, 0, 0));
    for (int c = 0; exp_q.size() != 0; c++) begin
      Resetn = !((c == 8) || (c == 9));
      Start  = (c == 0) || (c == 9) || (c == 10);
      Stop   = (c == 12);
      tick();
      got  = {W, En, LineStrobe, Done};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL reset_mid c=%0d got=%p want=%p", c, got, want);
      end
    end
    Resetn = 1'b1;
    Start  = 1'b0;
    Stop   = 1'b0;
  endtask

  task automatic test_mask;
    Dwell = 8'd3;
    Mode  = 1'b1;
    exp_q.push_back(mk(1, 0, 0, 0));
    exp_q.push_back(mk(1, 0, 0, 0));
    exp_q.push_back(mk(1, 1, 1, 0));
    exp_q.push_back(mk(1, 1, 0, 0));
    exp_q.push_back(mk(1, 1, 0, 0));
    exp_q.push_back(mk(1, 1, 0, 0));
    exp_q.push_back(mk(1, 1, 1, 0));
    exp_q.push_back(mk(1, 1, 0, 0));
    exp_q.push_back(mk(1, 1, 0, 0));
    exp_q.push_back(mk(1, 1, 0, 0));
    exp_q.push_back(mk(1, 0, 0, 1));
    exp_q.push_back(mk(1, 0, 0, 0));
    for (int c = 0; exp_q.size() != 0; c++) begin
      Mask  = ((c >= 2) && (c < 8)) ? 16'h0002 : 16'h0000;
      Start = (c == 0) || (c == 2);
      tick();
      got  = {W, En, LineStrobe, Done};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL mask c=%0d got=%p want=%p", c, got, want);
      end
    end
    Start = 1'b0;
  endtask

  task automatic test_long_dwell;
    Dwell = 8'hff;
    Mask  = 16'h0001;
    Mode  = 1'b0;
    exp_q.push_back(mk(0, 1, 1, 0));
    for (int i = 1; i < 256; i++) exp_q.push_back(mk(0, 1, 0, 0));
    exp_q.push_back(mk(0, 0, 0, 1));
    exp_q.push_back(mk(0, 0, 0, 0));
    for (int c = 0; exp_q.size() != 0; c++) begin
      Start = (c == 0);
      tick();
      got  = {W, En, LineStrobe, Done};
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL long_dwell c=%0d got=%p want=%p", c, got, want);
      end
    end
    Start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_sweep();
    test_continuous();
    test_stop();
    test_reset_mid();
    test_mask();
    test_long_dwell();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
